// File: rtl/alu_sincos_seq_pkg.sv
// Shared encodings for the sine/cosine sequencer: Taylor function selects,
// FSM state codes and the saturating negate used by the quadrant fix-up.
`ifndef ALU_TAYLOR_SIN
`define ALU_TAYLOR_SIN 3'b000
`endif
`ifndef ALU_TAYLOR_COS
`define ALU_TAYLOR_COS 3'b001
`endif
`ifndef ALU_SCS_IDLE
`define ALU_SCS_IDLE     3'd0
`define ALU_SCS_SCALE    3'd1
`define ALU_SCS_REQ_SIN  3'd2
`define ALU_SCS_WAIT_SIN 3'd3
`define ALU_SCS_REQ_COS  3'd4
`define ALU_SCS_WAIT_COS 3'd5
`define ALU_SCS_OUT      3'd6
`endif

package alu_sincos_seq_pkg;

    typedef enum logic [2:0] {
        SCS_IDLE     = `ALU_SCS_IDLE,
        SCS_SCALE    = `ALU_SCS_SCALE,
        SCS_REQ_SIN  = `ALU_SCS_REQ_SIN,
        SCS_WAIT_SIN = `ALU_SCS_WAIT_SIN,
        SCS_REQ_COS  = `ALU_SCS_REQ_COS,
        SCS_WAIT_COS = `ALU_SCS_WAIT_COS,
        SCS_OUT      = `ALU_SCS_OUT
    } scs_state_t;

    localparam logic [2:0] FSEL_SIN = `ALU_TAYLOR_SIN;
    localparam logic [2:0] FSEL_COS = `ALU_TAYLOR_COS;

    // -2.0 has no positive Q2.16 counterpart, so it clamps to the largest positive value
    function automatic logic [17:0] neg_sat(input logic [17:0] v);
        if (v == 18'h20000)
            return 18'h1FFFF;
        return ~v + 18'd1;
    endfunction

endpackage

// File: rtl/alu_quadrant_fix.sv
// Maps first-quadrant sin/cos results onto the full circle by quadrant swap
// and sign fix-up.
module alu_quadrant_fix
    import alu_sincos_seq_pkg::*;
(
    input  logic [1:0]  quad,
    input  logic [17:0] s_val,
    input  logic [17:0] c_val,
    output logic [17:0] sin_val,
    output logic [17:0] cos_val
);

    always_comb begin
        sin_val = s_val;
        cos_val = c_val;
        case (quad)
            2'd0: begin
                sin_val = s_val;
                cos_val = c_val;
            end
            2'd1: begin
                sin_val = c_val;
                cos_val = neg_sat(s_val);
            end
            2'd2: begin
                sin_val = neg_sat(s_val);
                cos_val = neg_sat(c_val);
            end
            default: begin
                sin_val = neg_sat(c_val);
                cos_val = s_val;
            end
        endcase
    end

endmodule

// File: rtl/alu_sincos_seq.sv
// Full-circle sine/cosine sequencer wrapped around the first-quadrant Taylor
// calculator: phase reduction, SIN then COS request, quadrant fix-up.
module alu_sincos_seq
    import alu_sincos_seq_pkg::*;
#(
    parameter logic [17:0] PI_HALF        = 18'h19220,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] phase_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [17:0] sin_out,
    output logic [17:0] cos_out,
    output logic        tc_do_calc,
    output logic [2:0]  tc_function_sel,
    output logic [17:0] tc_x_in,
    input  logic        tc_calc_done,
    input  logic [17:0] tc_result
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    scs_state_t       state;
    scs_state_t       state_nxt;
    logic [1:0]       quad;
    logic [15:0]      frac;
    logic [17:0]      s_reg;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    logic [16:0]      x_scaled;
    logic [17:0]      fix_sin;
    logic [17:0]      fix_cos;

    // First WAIT cycle sees count 0, so a wait lasts exactly TIMEOUT_CYCLES cycles
    assign timeout  = (wait_cnt == CNT_LAST);
    assign x_scaled = 17'((34'(frac) * 34'(PI_HALF[16:0])) >> 16);

    alu_quadrant_fix u_quadrant_fix (
        .quad    (quad),
        .s_val   (s_reg),
        .c_val   (tc_result),
        .sin_val (fix_sin),
        .cos_val (fix_cos)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= SCS_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCS_IDLE:     if (start) state_nxt = SCS_SCALE;
            SCS_SCALE:    state_nxt = SCS_REQ_SIN;
            SCS_REQ_SIN:  state_nxt = SCS_WAIT_SIN;
            SCS_WAIT_SIN: begin
                if (tc_calc_done)
                    state_nxt = SCS_REQ_COS;
                else if (timeout)
                    state_nxt = SCS_OUT;
            end
            SCS_REQ_COS:  state_nxt = SCS_WAIT_COS;
            SCS_WAIT_COS: if (tc_calc_done || timeout) state_nxt = SCS_OUT;
            SCS_OUT:      state_nxt = SCS_IDLE;
            default:      state_nxt = SCS_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != SCS_IDLE);
        done            = (state == SCS_OUT);
        tc_do_calc      = (state == SCS_REQ_SIN) || (state == SCS_REQ_COS);
        tc_function_sel = ((state == SCS_REQ_COS) || (state == SCS_WAIT_COS)) ? FSEL_COS : FSEL_SIN;
    end

    // Results are registered on the edge that captures C, so they are valid throughout OUT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quad     <= '0;
            frac     <= '0;
            s_reg    <= '0;
            wait_cnt <= '0;
            tc_x_in  <= '0;
            err      <= 1'b0;
            sin_out  <= '0;
            cos_out  <= '0;
        end else begin
            case (state)
                SCS_IDLE: begin
                    if (start) begin
                        quad <= phase_in[17:16];
                        frac <= phase_in[15:0];
                        err  <= 1'b0;
                    end
                end
                SCS_SCALE: tc_x_in <= {1'b0, x_scaled};
                SCS_REQ_SIN, SCS_REQ_COS: wait_cnt <= '0;
                SCS_WAIT_SIN: begin
                    if (tc_calc_done) begin
                        s_reg <= tc_result;
                    end else if (timeout) begin
                        err     <= 1'b1;
                        sin_out <= '0;
                        cos_out <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                SCS_WAIT_COS: begin
                    if (tc_calc_done) begin
                        sin_out <= fix_sin;
                        cos_out <= fix_cos;
                    end else if (timeout) begin
                        err     <= 1'b1;
                        sin_out <= '0;
                        cos_out <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sincos_seq.sv
// Self-checking bench for alu_sincos_seq with a latency-programmable Taylor
// calculator stub and a scoreboard of expected results.
module tb_alu_sincos_seq;
    import alu_sincos_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [17:0] phase_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [17:0] sin_out;
    logic [17:0] cos_out;
    logic        tc_do_calc;
    logic [2:0]  tc_function_sel;
    logic [17:0] tc_x_in;
    logic        tc_calc_done = 1'b0;
    logic [17:0] tc_result = '0;

    int tests = 0;
    int fails = 0;

    int          stub_l = 10;
    logic [17:0] stub_s = 18'h01234;
    logic [17:0] stub_c = 18'h0FEDC;
    bit          stub_respond = 1'b1;
    int          stub_cnt = 0;
    logic [2:0]  stub_sel = '0;

    typedef struct {
        logic [17:0] s;
        logic [17:0] c;
        logic        e;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_sincos_seq #(
        .PI_HALF        (18'h19220),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .phase_in        (phase_in),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .sin_out         (sin_out),
        .cos_out         (cos_out),
        .tc_do_calc      (tc_do_calc),
        .tc_function_sel (tc_function_sel),
        .tc_x_in         (tc_x_in),
        .tc_calc_done    (tc_calc_done),
        .tc_result       (tc_result)
    );

    // Stub: calc_done is sampled stub_l edges after the edge that samples tc_do_calc
    always @(negedge clk) begin
        tc_calc_done = 1'b0;
        if (!reset) begin
            stub_cnt = 0;
        end else begin
            if (stub_cnt != 0) begin
                stub_cnt--;
                if (stub_cnt == 0 && stub_respond) begin
                    tc_calc_done = 1'b1;
                    tc_result    = (stub_sel == FSEL_COS) ? stub_c : stub_s;
                end
            end
            if (tc_do_calc) begin
                stub_cnt = stub_l;
                stub_sel = tc_function_sel;
            end
        end
    end

    function automatic logic [17:0] x_model(input logic [15:0] f);
        longint unsigned p;
        p = longint'(f) * 64'h19220;
        return 18'(p >> 16);
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [17:0] phase,
                          input logic [17:0] es, input logic [17:0] ec, input logic ee,
                          input logic [17:0] exp_x, input int exp_ndo,
                          input int lat_min, input int lat_max, input bit hammer);
        exp_t        e;
        int          cyc;
        int          ndo;
        int          ndone;
        bit          busy_drop;
        bit          extra;
        logic [2:0]  sel_log[2];
        logic [17:0] x_log[2];
        @(negedge clk);
        phase_in = phase;
        start    = 1'b1;
        sb.push_back('{s: es, c: ec, e: ee});
        cyc = 0; ndo = 0; ndone = 0; busy_drop = 1'b0; extra = 1'b0;
        while (ndone == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start    = hammer;
            phase_in = hammer ? ~phase : phase;
            if (tc_do_calc) begin
                if (ndo < 2) begin
                    sel_log[ndo] = tc_function_sel;
                    x_log[ndo]   = tc_x_in;
                end
                ndo++;
            end
            if (!busy) busy_drop = 1'b1;
            if (done) ndone++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, " done_seen"}, 18'(ndone), 18'd1);
        chk({tag, " sin_out"}, sin_out, e.s);
        chk({tag, " cos_out"}, cos_out, e.c);
        chk({tag, " err"}, 18'(err), 18'(e.e));
        chk({tag, " latency"}, 18'(cyc >= lat_min && cyc <= lat_max), 18'd1);
        chk({tag, " n_do_calc"}, 18'(ndo), 18'(exp_ndo));
        chk({tag, " busy_held"}, 18'(busy_drop), 18'd0);
        if (exp_ndo >= 1) begin
            chk({tag, " sel_first"}, 18'(sel_log[0]), 18'(FSEL_SIN));
            chk({tag, " x_first"}, x_log[0], exp_x);
        end
        if (exp_ndo >= 2) begin
            chk({tag, " sel_second"}, 18'(sel_log[1]), 18'(FSEL_COS));
            chk({tag, " x_second"}, x_log[1], exp_x);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || tc_do_calc || busy) extra = 1'b1;
        end
        chk({tag, " idle_after"}, 18'(extra), 18'd0);
        chk({tag, " sin_hold"}, sin_out, e.s);
        chk({tag, " err_hold"}, 18'(err), 18'(e.e));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          guard;
        int          ndone_rst;
        logic [17:0] x1;

        reset    = 1'b0;
        start    = 1'b0;
        phase_in = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", 18'(busy), 18'd0);
        chk("rst done", 18'(done), 18'd0);
        chk("rst err", 18'(err), 18'd0);
        chk("rst sin", sin_out, 18'd0);
        chk("rst cos", cos_out, 18'd0);
        chk("rst do_calc", 18'(tc_do_calc), 18'd0);
        chk("rst x_in", tc_x_in, 18'd0);
        chk("rst sel", 18'(tc_function_sel), 18'(FSEL_SIN));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_op("q0_mid", 18'h08000, 18'h01234, 18'h0FEDC, 1'b0, 18'h0C910, 2, 24, 24, 1'b0);
        run_op("q1", 18'h10000, 18'h0FEDC, 18'h3EDCC, 1'b0, 18'h00000, 2, 24, 24, 1'b0);
        run_op("q2", 18'h20000, 18'h3EDCC, 18'h30124, 1'b0, 18'h00000, 2, 24, 24, 1'b0);
        run_op("q3", 18'h30000, 18'h30124, 18'h01234, 1'b0, 18'h00000, 2, 24, 24, 1'b0);

        stub_s = 18'h20000;
        run_op("q3_max", 18'h3FFFF, 18'h30124, 18'h20000, 1'b0, 18'h1921E, 2, 24, 24, 1'b0);
        run_op("q2_sat", 18'h2FFFF, 18'h1FFFF, 18'h30124, 1'b0, 18'h1921E, 2, 24, 24, 1'b0);

        stub_s = 18'h01234;
        run_op("hammer", 18'h08000, 18'h01234, 18'h0FEDC, 1'b0, 18'h0C910, 2, 24, 24, 1'b1);

        stub_l = 1;
        stub_s = 18'h05555;
        stub_c = 18'h0AAAA;
        x1 = x_model(16'hABCD);
        run_op("lat1", 18'h1ABCD, 18'h0AAAA, 18'h3AAAB, 1'b0, x1, 2, 6, 6, 1'b0);

        stub_l = 10;
        stub_s = 18'h01234;
        stub_c = 18'h0FEDC;
        stub_respond = 1'b0;
        run_op("timeout", 18'h08000, 18'h00000, 18'h00000, 1'b1, 18'h0C910, 1, 255, 265, 1'b0);
        stub_respond = 1'b1;
        run_op("err_clear", 18'h08000, 18'h01234, 18'h0FEDC, 1'b0, 18'h0C910, 2, 24, 24, 1'b0);

        // Reset during WAIT_COS: outputs drop at once, no done pulse
        @(negedge clk);
        phase_in = 18'h10000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(tc_do_calc && tc_function_sel == FSEL_COS) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid reached_req_cos", 18'(guard < 100), 18'd1);
        repeat (3) @(negedge clk);
        chk("rst_mid in_wait_cos", 18'(busy && !tc_do_calc && tc_function_sel == FSEL_COS), 18'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid busy", 18'(busy), 18'd0);
        chk("rst_mid done", 18'(done), 18'd0);
        chk("rst_mid sin", sin_out, 18'd0);
        chk("rst_mid cos", cos_out, 18'd0);
        chk("rst_mid x_in", tc_x_in, 18'd0);
        chk("rst_mid sel", 18'(tc_function_sel), 18'(FSEL_SIN));
        ndone_rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) ndone_rst++;
        end
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) ndone_rst++;
        end
        chk("rst_mid no_done", 18'(ndone_rst), 18'd0);
        run_op("after_rst", 18'h20000, 18'h3EDCC, 18'h30124, 1'b0, 18'h00000, 2, 24, 24, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
